// File: rtl/pe_ctrl_pkg.sv
// Shared types and default widths for the PE controller and its tap/channel counter.
package pe_ctrl_pkg;

  localparam int CFG_W_DEF      = 5;
  localparam int PSUM_W_DEF     = 8;
  localparam int PIPE_DEPTH_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pe_tap_ch_counter.sv
// Nested tap/channel wrap counter; `last` flags the final tap of the final channel.
module pe_tap_ch_counter
  import pe_ctrl_pkg::*;
#(
  parameter int W = CFG_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tap_max,
  input  logic [W-1:0] ch_max,
  output logic [W-1:0] tap_idx,
  output logic [W-1:0] ch_idx,
  output logic         last
);

  logic [W-1:0] tap_q, tap_d, ch_q, ch_d;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      tap_q <= '0;
      ch_q  <= '0;
    end else if (inc) begin
      tap_q <= tap_d;
      ch_q  <= ch_d;
    end
  end

  always_comb begin
    tap_d = tap_q + W'(1);
    ch_d  = ch_q;
    if (tap_q == tap_max) begin
      tap_d = '0;
      ch_d  = (ch_q == ch_max) ? '0 : ch_q + W'(1);
    end
  end

  assign tap_idx = tap_q;
  assign ch_idx  = ch_q;
  assign last    = (tap_q == tap_max) && (ch_q == ch_max);

endmodule

// File: rtl/pe_ctrl_multi.sv
// PE MAC-pipeline sequencer: taps x channels per psum, psums per pass, valid/ready psum hand-off.
// Optional PE_CTRL_PERF_CNT_EN adds saturating busy/stall cycle counters.
//
// state    | meaning
// IDLE     | wait for both scratchpads, spad counters held clear
// RUN      | issue one MAC per cycle over all taps/channels
// DRAIN    | wait for in-flight MACs to retire
// WRITE    | present psum until downstream accepts
// DONE     | one-cycle end-of-pass pulse
module pe_ctrl_multi
  import pe_ctrl_pkg::*;
#(
  parameter int CFG_W      = CFG_W_DEF,
  parameter int PSUM_W     = PSUM_W_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  iact_spad_ready,
  input  logic                  weight_spad_ready,
  input  logic [CFG_W-1:0]      filter_size,
  input  logic [CFG_W-1:0]      num_channels,
  input  logic [PSUM_W-1:0]     num_psums,
  input  logic                  psum_ready,
  output logic                  pipe_en,
  output logic [PIPE_DEPTH-1:0] pipe_valid,
  output logic                  acc_clear,
  output logic [CFG_W-1:0]      tap_idx,
  output logic [CFG_W-1:0]      ch_idx,
  output logic                  psum_valid,
  output logic                  psum_write_cnt_en,
  output logic                  counter_clear,
  output logic                  busy,
`ifdef PE_CTRL_PERF_CNT_EN
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic                  done
);

  state_e                state_q, state_d;
  logic                  iact_seen_q, iact_seen_d, wt_seen_q, wt_seen_d;
  logic [CFG_W-1:0]      fs_max_q, fs_max_d, ch_max_q, ch_max_d;
  logic [PSUM_W-1:0]     np_max_q, np_max_d, psum_cnt_q, psum_cnt_d;
  logic [PIPE_DEPTH-1:0] pv_q, pv_d;
  logic                  cnt_inc, cnt_clr, tc_last;

  assign cnt_clr = en && flush;
  assign cnt_inc = en && !flush && (state_q == ST_RUN);

  pe_tap_ch_counter #(.W(CFG_W)) u_tap_ch (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .tap_max (fs_max_q),
    .ch_max  (ch_max_q),
    .tap_idx (tap_idx),
    .ch_idx  (ch_idx),
    .last    (tc_last)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      iact_seen_q <= 1'b0;
      wt_seen_q   <= 1'b0;
      fs_max_q    <= '0;
      ch_max_q    <= '0;
      np_max_q    <= '0;
      psum_cnt_q  <= '0;
      pv_q        <= '0;
    end else if (en) begin
      state_q     <= state_d;
      iact_seen_q <= iact_seen_d;
      wt_seen_q   <= wt_seen_d;
      fs_max_q    <= fs_max_d;
      ch_max_q    <= ch_max_d;
      np_max_q    <= np_max_d;
      psum_cnt_q  <= psum_cnt_d;
      pv_q        <= pv_d;
    end
  end

  // Config is stored as last index (value-1) so a programmed 0 behaves as 1.
  always_comb begin
    state_d     = state_q;
    iact_seen_d = iact_seen_q;
    wt_seen_d   = wt_seen_q;
    fs_max_d    = fs_max_q;
    ch_max_d    = ch_max_q;
    np_max_d    = np_max_q;
    psum_cnt_d  = psum_cnt_q;
    pv_d        = pv_q << 1;
    pv_d[0]     = (state_q == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        iact_seen_d = iact_seen_q || iact_spad_ready;
        wt_seen_d   = wt_seen_q || weight_spad_ready;
        if (iact_seen_d && wt_seen_d) begin
          state_d     = ST_RUN;
          iact_seen_d = 1'b0;
          wt_seen_d   = 1'b0;
          fs_max_d    = (filter_size == '0) ? '0 : filter_size - CFG_W'(1);
          ch_max_d    = (num_channels == '0) ? '0 : num_channels - CFG_W'(1);
          np_max_d    = (num_psums == '0) ? '0 : num_psums - PSUM_W'(1);
        end
      end
      ST_RUN:   if (tc_last) state_d = ST_DRAIN;
      ST_DRAIN: if (pv_d == '0) state_d = ST_WRITE;
      ST_WRITE: begin
        if (psum_ready) begin
          if (psum_cnt_q == np_max_q) begin
            psum_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            psum_cnt_d = psum_cnt_q + PSUM_W'(1);
            state_d    = ST_RUN;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      iact_seen_d = 1'b0;
      wt_seen_d   = 1'b0;
      psum_cnt_d  = '0;
      pv_d        = '0;
    end
  end

  always_comb begin
    pipe_en           = 1'b0;
    acc_clear         = 1'b0;
    psum_valid        = 1'b0;
    psum_write_cnt_en = 1'b0;
    counter_clear     = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        counter_clear = 1'b1;
        busy          = 1'b0;
      end
      ST_RUN: begin
        pipe_en   = en && !flush;
        acc_clear = (tap_idx == '0) && (ch_idx == '0);
      end
      ST_WRITE: begin
        psum_valid        = 1'b1;
        psum_write_cnt_en = en && !flush && psum_ready;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pipe_valid = pv_q;

`ifdef PE_CTRL_PERF_CNT_EN
  logic [31:0] busy_cyc_q, stall_cyc_q;
  logic        in_work;

  assign in_work = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else if (en) begin
      if (flush) begin
        busy_cyc_q  <= '0;
        stall_cyc_q <= '0;
      end else begin
        if (in_work && (busy_cyc_q != '1)) busy_cyc_q <= busy_cyc_q + 32'd1;
        if ((state_q == ST_WRITE) && !psum_ready && (stall_cyc_q != '1))
          stall_cyc_q <= stall_cyc_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles  = busy_cyc_q;
  assign perf_stall_cycles = stall_cyc_q;
`endif

endmodule
